// File: rtl/rename_pkg.sv
// Shared rename-stage definitions.
// Holds the default free-list geometry, the tag and checkpoint-id types, and the
// free-list controller state enum. Imported by free_list_ctrl.
package rename_pkg;

   localparam int unsigned DEF_NUM_PHYS = 64;
   localparam int unsigned DEF_NUM_ARCH = 32;
   localparam int unsigned DEF_NUM_CKPT = 4;

   typedef logic [$clog2(DEF_NUM_PHYS)-1:0] preg_t;
   typedef logic [$clog2(DEF_NUM_CKPT)-1:0] ckpt_id_t;

   typedef enum logic [1:0] {
      INIT,
      RUN,
      RECOVER
   } fl_state_t;

endpackage

// File: rtl/free_list_ring.sv
// Free-list storage: DEPTH x WIDTH ring RAM, one synchronous write port and one
// asynchronous read port. Contents are not reset; the controller fills them.
// Ports:
//   clk_i    rising-edge clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data (combinational)
module free_list_ring #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned WIDTH = 6
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/free_list_ctrl.sv
// Physical-register free-list controller for rename.
// Serves one tag allocation per cycle (same-cycle grant), accepts one release per
// cycle from commit, and keeps a circular queue of head-pointer checkpoints so a
// mispredict restores every tag allocated after the branch in one step.
// Optional feature macro: FREE_LIST_BYPASS_EN -- when defined, an allocation at an
// empty list is served directly from a simultaneous release.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   alloc_req/alloc_gnt      allocation handshake; alloc_preg valid with alloc_gnt
//   rel_valid/rel_preg       tag release from commit
//   ckpt_save/ckpt_id        take a checkpoint; ckpt_id is the slot it uses
//   ckpt_full                all slots live, saves ignored
//   ckpt_restore(_id)        mispredict restore of a slot
//   ckpt_release             retire oldest live checkpoint
//   ready, free_count        init done, number of free tags
//   overflow                 sticky: release attempted while list full
module free_list_ctrl
   import rename_pkg::*;
#(
   parameter int unsigned NUM_PHYS = DEF_NUM_PHYS,
   parameter int unsigned NUM_ARCH = DEF_NUM_ARCH,
   parameter int unsigned NUM_CKPT = DEF_NUM_CKPT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          alloc_req,
   output logic                          alloc_gnt,
   output logic [$clog2(NUM_PHYS)-1:0]   alloc_preg,
   input  logic                          rel_valid,
   input  logic [$clog2(NUM_PHYS)-1:0]   rel_preg,
   input  logic                          ckpt_save,
   output logic [$clog2(NUM_CKPT)-1:0]   ckpt_id,
   output logic                          ckpt_full,
   input  logic                          ckpt_restore,
   input  logic [$clog2(NUM_CKPT)-1:0]   ckpt_restore_id,
   input  logic                          ckpt_release,
   output logic                          ready,
   output logic [$clog2(NUM_PHYS+1)-1:0] free_count,
   output logic                          overflow
);

   localparam int unsigned PW = $clog2(NUM_PHYS);
   localparam int unsigned CW = $clog2(NUM_PHYS + 1);
   localparam int unsigned KW = $clog2(NUM_CKPT);

   localparam logic [CW-1:0] FULL_CNT  = CW'(NUM_PHYS);
   localparam logic [CW-1:0] INIT_LAST = CW'(NUM_PHYS - NUM_ARCH - 1);
   localparam logic [PW-1:0] ARCH_BASE = PW'(NUM_ARCH);

   fl_state_t state_q, state_d;

   logic [PW-1:0]       head_q, head_d;
   logic [PW-1:0]       tail_q, tail_d;
   logic [CW-1:0]       count_q, count_d;
   logic                overflow_q, overflow_d;
   logic [NUM_CKPT-1:0] ckpt_valid_q, ckpt_valid_d;
   logic [KW-1:0]       ckpt_alloc_q, ckpt_alloc_d;
   logic [KW-1:0]       ckpt_old_q, ckpt_old_d;
   logic [PW-1:0]       ckpt_head_q [NUM_CKPT];
   logic [PW-1:0]       ckpt_head_d [NUM_CKPT];

   logic          active;
   logic          restore_hit;
   logic          list_empty;
   logic          list_full;
   logic          bypass;
   logic          ring_gnt;
   logic          rel_acc;
   logic          save_acc;
   logic          ckpt_rel_acc;
   logic          ring_we;
   logic [PW-1:0] ring_wdata;
   logic [PW-1:0] ring_rdata;
   logic [KW-1:0] rest_dist;
   logic [KW-1:0] slot_dist;

   free_list_ring #(
      .DEPTH (NUM_PHYS),
      .WIDTH (PW)
   ) u_ring (
      .clk_i   (clk),
      .we_i    (ring_we),
      .waddr_i (tail_q),
      .wdata_i (ring_wdata),
      .raddr_i (head_q),
      .rdata_o (ring_rdata)
   );

   // Grant / release decode.
   always_comb begin
      active      = (state_q != INIT);
      restore_hit = active & ckpt_restore & ckpt_valid_q[ckpt_restore_id];
      list_empty  = (count_q == '0);
      list_full   = (count_q == FULL_CNT);
`ifdef FREE_LIST_BYPASS_EN
      bypass = (state_q == RUN) & ~restore_hit & list_empty & alloc_req & rel_valid;
`else
      bypass = 1'b0;
`endif
      ring_gnt = (state_q == RUN) & ~restore_hit & alloc_req & ~list_empty;
      // A bypassed release is consumed by the grant and never touches the ring.
      rel_acc  = active & rel_valid & ~list_full & ~bypass;

      ring_we    = (state_q == INIT) | rel_acc;
      ring_wdata = (state_q == INIT) ? (tail_q + ARCH_BASE) : rel_preg;

      alloc_gnt = ring_gnt | bypass;
      if (bypass) begin
         alloc_preg = rel_preg;
      end else if (ring_gnt) begin
         alloc_preg = ring_rdata;
      end else begin
         alloc_preg = '0;
      end
   end

   // Next-state for pointers, count, state and checkpoint queue.
   always_comb begin
      state_d      = state_q;
      head_d       = head_q + PW'(ring_gnt);
      tail_d       = tail_q + PW'(ring_we);
      count_d      = count_q + CW'(ring_we) - CW'(ring_gnt);
      overflow_d   = overflow_q | (active & rel_valid & list_full);
      ckpt_valid_d = ckpt_valid_q;
      ckpt_alloc_d = ckpt_alloc_q;
      ckpt_old_d   = ckpt_old_q;
      ckpt_head_d  = ckpt_head_q;
      rest_dist    = ckpt_restore_id - ckpt_old_q;
      slot_dist    = '0;

      save_acc     = active & ckpt_save & ~(&ckpt_valid_q) & ~restore_hit;
      // Releasing the slot being restored would leave oldest ahead of alloc.
      ckpt_rel_acc = active & ckpt_release & ckpt_valid_q[ckpt_old_q] &
                     ~(restore_hit & (ckpt_restore_id == ckpt_old_q));

      unique case (state_q)
         INIT:    if (count_q == INIT_LAST) state_d = RUN;
         RUN:     if (restore_hit) state_d = RECOVER;
         RECOVER: state_d = restore_hit ? RECOVER : RUN;
         default: state_d = INIT;
      endcase

      if (restore_hit) begin
         head_d  = ckpt_head_q[ckpt_restore_id];
         // Everything between the saved head and the new tail is free again.
         count_d = CW'(tail_d - ckpt_head_q[ckpt_restore_id]);
      end

      if (ckpt_rel_acc) begin
         ckpt_valid_d[ckpt_old_q] = 1'b0;
         ckpt_old_d               = ckpt_old_q + KW'(1);
      end

      if (save_acc) begin
         ckpt_head_d[ckpt_alloc_q]  = head_d;
         ckpt_valid_d[ckpt_alloc_q] = 1'b1;
         ckpt_alloc_d               = ckpt_alloc_q + KW'(1);
      end

      if (restore_hit) begin
         // Age is measured from the oldest slot so a full queue is handled too.
         for (int i = 0; i < NUM_CKPT; i++) begin
            slot_dist = KW'(i) - ckpt_old_q;
            if (ckpt_valid_q[i] && (slot_dist >= rest_dist)) begin
               ckpt_valid_d[i] = 1'b0;
            end
         end
         ckpt_alloc_d = ckpt_restore_id;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= INIT;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         ckpt_valid_q <= '0;
         ckpt_alloc_q <= '0;
         ckpt_old_q   <= '0;
         for (int i = 0; i < NUM_CKPT; i++) begin
            ckpt_head_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         ckpt_valid_q <= ckpt_valid_d;
         ckpt_alloc_q <= ckpt_alloc_d;
         ckpt_old_q   <= ckpt_old_d;
         ckpt_head_q  <= ckpt_head_d;
      end
   end

   assign ready      = (state_q != INIT);
   assign free_count = count_q;
   assign overflow   = overflow_q;
   assign ckpt_id    = ckpt_alloc_q;
   assign ckpt_full  = &ckpt_valid_q;

endmodule

// File: tb/tb_free_list_ctrl.sv
module tb_free_list_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       alloc_req;
   logic       alloc_gnt;
   logic [5:0] alloc_preg;
   logic       rel_valid;
   logic [5:0] rel_preg;
   logic       ckpt_save;
   logic [1:0] ckpt_id;
   logic       ckpt_full;
   logic       ckpt_restore;
   logic [1:0] ckpt_restore_id;
   logic       ckpt_release;
   logic       ready;
   logic [6:0] free_count;
   logic       overflow;

   always #5 clk = ~clk;

   free_list_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .alloc_req       (alloc_req),
      .alloc_gnt       (alloc_gnt),
      .alloc_preg      (alloc_preg),
      .rel_valid       (rel_valid),
      .rel_preg        (rel_preg),
      .ckpt_save       (ckpt_save),
      .ckpt_id         (ckpt_id),
      .ckpt_full       (ckpt_full),
      .ckpt_restore    (ckpt_restore),
      .ckpt_restore_id (ckpt_restore_id),
      .ckpt_release    (ckpt_release),
      .ready           (ready),
      .free_count      (free_count),
      .overflow        (overflow)
   );

   typedef struct {
      logic       alloc;
      logic       rel;
      logic [5:0] relp;
      logic       gnt;
      logic [5:0] preg;
      logic [6:0] cnt;
   } vec_t;

   vec_t vecs [160];
   int   nvec   = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic a, input logic r, input int rp,
                      input logic g, input int p, input int c);
      vecs[nvec].alloc = a;
      vecs[nvec].rel   = r;
      vecs[nvec].relp  = 6'(rp);
      vecs[nvec].gnt   = g;
      vecs[nvec].preg  = 6'(p);
      vecs[nvec].cnt   = 7'(c);
      nvec++;
   endtask

   task automatic idle_inputs();
      alloc_req       = 1'b0;
      rel_valid       = 1'b0;
      rel_preg        = '0;
      ckpt_save       = 1'b0;
      ckpt_restore    = 1'b0;
      ckpt_restore_id = '0;
      ckpt_release    = 1'b0;
   endtask

   // Reset, then wait (bounded) for ready; returns the number of cycles taken.
   task automatic do_reset(output int n);
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n = 0;
      while (!ready && n < 100) begin
         tick();
         n++;
      end
   endtask

   function automatic int rel_tag(input int k);
      return (k * 7 + 3) % 64;
   endfunction

   initial begin
      int n;

      // Directed vector table, continuing from a fresh init (head=0, 32 free).
      for (int i = 0; i < 32; i++) add(1, 0, 0, 1, 32 + i, 32 - i);
      add(1, 0, 0, 0, 0, 0);           // 33rd request refused
      add(0, 1, 5, 0, 0, 0);           // release tag 5
      add(1, 0, 0, 1, 5, 1);           // ...granted next cycle
      add(0, 0, 0, 0, 0, 0);
`ifdef FREE_LIST_BYPASS_EN
      add(1, 1, 7, 1, 7, 0);           // bypass at empty list
      add(1, 0, 0, 0, 0, 0);
`else
      add(1, 1, 7, 0, 0, 0);           // written, not granted
      add(1, 0, 0, 1, 7, 1);
`endif
      add(0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 10; k++) add(0, 1, 8 + k, 0, 0, k);
      // Paired alloc/release at 10 free; 70 pairs wrap both pointers.
      for (int k = 0; k < 70; k++) begin
         add(1, 1, rel_tag(k), 1, (k < 10) ? (8 + k) : rel_tag(k - 10), 10);
      end
      add(0, 0, 0, 0, 0, 10);

      // Reset values.
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      chk("rst_alloc_gnt", alloc_gnt, 0);
      chk("rst_alloc_preg", alloc_preg, 0);
      chk("rst_ckpt_id", ckpt_id, 0);
      chk("rst_ckpt_full", ckpt_full, 0);
      chk("rst_ready", ready, 0);
      chk("rst_free_count", free_count, 0);
      chk("rst_overflow", overflow, 0);

      rst = 1'b0;
      alloc_req = 1'b1;
      #1;
      chk("init_no_gnt", alloc_gnt, 0);
      alloc_req = 1'b0;
      n = 0;
      while (!ready && n < 100) begin
         tick();
         n++;
      end
      chk("ready_latency", n, 32);
      chk("init_free_count", free_count, 32);

      for (int i = 0; i < nvec; i++) begin
         alloc_req = vecs[i].alloc;
         rel_valid = vecs[i].rel;
         rel_preg  = vecs[i].relp;
         #1;
         if (alloc_gnt !== vecs[i].gnt || alloc_preg !== vecs[i].preg ||
             free_count !== vecs[i].cnt) begin
            $display("FAIL vec%0d: got gnt=%0d preg=%0d cnt=%0d expected gnt=%0d preg=%0d cnt=%0d",
                     i, alloc_gnt, alloc_preg, free_count, vecs[i].gnt, vecs[i].preg,
                     vecs[i].cnt);
            errors++;
         end
         checks++;
         tick();
      end
      idle_inputs();

      // Checkpoint save / restore.
      do_reset(n);
      chk("reset2_ready", n, 32);
      for (int i = 0; i < 8; i++) begin
         alloc_req = 1'b1;
         #1;
         chk("pre_ckpt_alloc", alloc_preg, 32 + i);
         tick();
      end
      alloc_req = 1'b0;
      ckpt_save = 1'b1;
      #1;
      chk("save0_id", ckpt_id, 0);
      tick();
      ckpt_save = 1'b0;
      for (int i = 0; i < 3; i++) begin
         alloc_req = 1'b1;
         #1;
         chk("post_ckpt_alloc", alloc_preg, 40 + i);
         tick();
      end
      alloc_req = 1'b0;
      ckpt_save = 1'b1;
      #1;
      chk("save1_id", ckpt_id, 1);
      tick();
      ckpt_save = 1'b0;
      ckpt_restore    = 1'b1;
      ckpt_restore_id = 2'd0;
      rel_valid       = 1'b1;
      rel_preg        = 6'd9;
      alloc_req       = 1'b1;
      #1;
      chk("restore_cycle_gnt", alloc_gnt, 0);
      tick();
      ckpt_restore = 1'b0;
      rel_valid    = 1'b0;
      #1;
      chk("recover_cycle_gnt", alloc_gnt, 0);
      chk("restore_count", free_count, 25);
      chk("restore_ckpt_id", ckpt_id, 0);
      tick();
      ckpt_restore    = 1'b1;
      ckpt_restore_id = 2'd1;       // invalidated by the restore: ignored
      #1;
      chk("stale_restore_gnt", alloc_gnt, 1);
      chk("restored_head_tag", alloc_preg, 40);
      tick();
      ckpt_restore = 1'b0;
      alloc_req    = 1'b0;
      #1;
      chk("after_stale_count", free_count, 24);

      // Fill all checkpoint slots.
      for (int i = 0; i < 4; i++) begin
         ckpt_save = 1'b1;
         #1;
         chk("fill_id", ckpt_id, i);
         tick();
      end
      ckpt_save = 1'b0;
      #1;
      chk("full_set", ckpt_full, 1);
      ckpt_save = 1'b1;
      tick();
      ckpt_save = 1'b0;
      #1;
      chk("save_when_full_id", ckpt_id, 0);
      chk("save_when_full_full", ckpt_full, 1);
      ckpt_release = 1'b1;
      tick();
      ckpt_release = 1'b0;
      #1;
      chk("release_full", ckpt_full, 0);
      chk("release_id", ckpt_id, 0);
      ckpt_save = 1'b1;
      #1;
      chk("resave_id", ckpt_id, 0);
      tick();
      ckpt_save = 1'b0;
      #1;
      chk("refull", ckpt_full, 1);
      // Oldest is slot 1; restoring slot 2 kills 2, 3 and 0.
      ckpt_restore    = 1'b1;
      ckpt_restore_id = 2'd2;
      tick();
      ckpt_restore = 1'b0;
      #1;
      chk("wrap_restore_id", ckpt_id, 2);
      chk("wrap_restore_full", ckpt_full, 0);
      tick();
      #1;
      chk("wrap_restore_count", free_count, 24);
      ckpt_save = 1'b1;
      #1;
      chk("wrap_save_id", ckpt_id, 2);
      tick();
      ckpt_save       = 1'b0;
      ckpt_restore    = 1'b1;
      ckpt_restore_id = 2'd3;       // invalid slot: ignored
      alloc_req       = 1'b1;
      #1;
      chk("invalid_restore_gnt", alloc_gnt, 1);
      chk("invalid_restore_preg", alloc_preg, 41);
      tick();
      idle_inputs();

      // Overflow: fill the list, then release once more.
      for (int i = 0; i < 41; i++) begin
         rel_valid = 1'b1;
         rel_preg  = 6'(i);
         tick();
      end
      rel_valid = 1'b0;
      #1;
      chk("full_count", free_count, 64);
      chk("no_overflow_yet", overflow, 0);
      rel_valid = 1'b1;
      tick();
      rel_valid = 1'b0;
      #1;
      chk("overflow_set", overflow, 1);
      chk("overflow_count", free_count, 64);
      rst = 1'b1;
      tick();
      chk("rst_clears_overflow", overflow, 0);
      chk("rst_clears_ckpt_id", ckpt_id, 0);
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
